// File: rtl/pixel_window_gen.sv
// pixel_window_gen: turns a raster RGB pixel stream into 3x3 windows.
// Ports: clk, rst | pixel_in/valid/ready in | pixelData/window_valid/ready out | frame_done, busy.
module pixel_window_gen #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16,
  parameter int COL_BITS   = 4,
  parameter int ROW_BITS   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [23:0]  pixel_in,
  input  logic         pixel_valid,
  output logic         pixel_ready,
  output logic [215:0] pixelData,
  output logic         window_valid,
  input  logic         window_ready,
  output logic         frame_done,
  output logic         busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);

  logic [1:0]          state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [71:0]         win0_q, win0_d;
  logic [71:0]         win1_q, win1_d;
  logic [71:0]         win2_q, win2_d;
  logic [215:0]        pix_q, pix_d;
  logic                wv_q, wv_d;

  logic [23:0] line1_q [IMG_WIDTH];
  logic [23:0] line2_q [IMG_WIDTH];

  logic        accept;
  logic        col_end;
  logic        row_end;
  logic        emit;
  logic [71:0] new_col;

  assign pixel_ready  = !wv_q || window_ready;
  assign accept       = pixel_valid && pixel_ready;
  assign col_end      = (col_q == COL_LAST);
  assign row_end      = (row_q == ROW_LAST);
  assign emit         = accept
                     && (row_q >= ROW_BITS'(2))
                     && (col_q >= COL_BITS'(2));
  // Column layout is {top, mid, bottom}; the newest pixel is the bottom.
  assign new_col      = {line2_q[col_q], line1_q[col_q], pixel_in};

  assign pixelData    = pix_q;
  assign window_valid = wv_q;
  assign frame_done   = (state_q == S_DONE);
  assign busy         = (state_q == S_FILL) || (state_q == S_STREAM);

  always_comb begin
    win0_d = win0_q;
    win1_d = win1_q;
    win2_d = win2_q;
    if (accept) begin
      win0_d = win1_q;
      win1_d = win2_q;
      win2_d = new_col;
    end
  end

  // Row-major pack of the shifted window: top row, middle row, bottom row.
  always_comb begin
    pix_d = pix_q;
    if (emit) begin
      pix_d = {win1_q[71:48], win2_q[71:48], new_col[71:48],
               win1_q[47:24], win2_q[47:24], new_col[47:24],
               win1_q[23:0],  win2_q[23:0],  new_col[23:0]};
    end
  end

  always_comb begin
    wv_d = wv_q && !window_ready;
    if (emit) begin
      wv_d = 1'b1;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_BITS'(1);
      end else begin
        col_d = col_q + COL_BITS'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (accept) state_d = S_FILL;
      end
      (state_q == S_FILL): begin
        if (accept && col_end && row_q == ROW_BITS'(1))
          state_d = S_STREAM;
      end
      (state_q == S_STREAM): begin
        if (accept && col_end && row_end)
          state_d = S_DONE;
      end
      (state_q == S_DONE): begin
        // A pixel taken here is (0,0) of the next frame.
        state_d = accept ? S_FILL : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win0_q  <= '0;
      win1_q  <= '0;
      win2_q  <= '0;
      pix_q   <= '0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win0_q  <= win0_d;
      win1_q  <= win1_d;
      win2_q  <= win2_d;
      pix_q   <= pix_d;
      wv_q    <= wv_d;
    end
  end

  // Line buffers need no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      line2_q[col_q] <= line1_q[col_q];
      line1_q[col_q] <= pixel_in;
    end
  end

endmodule

// File: tb/tb_pixel_window_gen.sv
// tb_pixel_window_gen: scoreboard bench for pixel_window_gen at 4x4.
// Ports: none; drives the DUT and prints one summary line.
module tb_pixel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    logic [215:0] d;
    bit           last;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  pixel_in;
  logic         pixel_valid;
  logic         pixel_ready;
  logic [215:0] pixelData;
  logic         window_valid;
  logic         window_ready;
  logic         frame_done;
  logic         busy;

  int   chk = 0;
  int   err = 0;
  int   cyc = 0;
  int   win_cnt = 0;
  exp_t sb[$];
  exp_t e;
  logic [23:0] img [H][W];
  bit   prev_wv = 1'b0;
  bit   prev_hs = 1'b0;

  pixel_window_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_BITS  (2),
    .ROW_BITS  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixelData   (pixelData),
    .window_valid(window_valid),
    .window_ready(window_ready),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pix(input int idx);
    logic [7:0] v;
    v = idx[7:0];
    return {v, v + 8'd64, v + 8'd128};
  endfunction

  function automatic logic [7:0] intens(input logic [23:0] p);
    return (p[23:16] >> 2) + (p[15:8] >> 1) + (p[7:0] >> 2);
  endfunction

  function automatic logic [215:0] build(input int r, input int c);
    logic [215:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[215 - 24 * (dr * 3 + dc) -: 24] = img[r - 2 + dr][c - 2 + dc];
    return w;
  endfunction

  // Monitor: checks every window on its first valid cycle.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_wv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (window_valid && (!prev_wv || prev_hs)) begin
        win_cnt++;
        chk++;
        if (sb.size() == 0) begin
          err++;
          $display("FAIL unexpected_window got=%h", pixelData);
        end else begin
          int bad;
          e = sb.pop_front();
          if (pixelData !== e.d) begin
            err++;
            $display("FAIL window_data got=%h exp=%h", pixelData, e.d);
          end
          chk++;
          if (cyc !== e.due) begin
            err++;
            $display("FAIL window_latency got=%0d exp=%0d", cyc, e.due);
          end
          chk++;
          if (frame_done !== e.last) begin
            err++;
            $display("FAIL frame_done got=%b exp=%b", frame_done, e.last);
          end
          chk++;
          if (busy !== !e.last) begin
            err++;
            $display("FAIL busy_at_window got=%b exp=%b", busy, !e.last);
          end
          bad = 0;
          for (int k = 0; k < 9; k++)
            if (intens(pixelData[215 - 24 * k -: 24]) !==
                intens(e.d[215 - 24 * k -: 24])) bad++;
          chk++;
          if (bad != 0) begin
            err++;
            $display("FAIL intensity got=%0d bad bytes exp=0", bad);
          end
        end
      end
      prev_wv = window_valid;
      prev_hs = window_valid && window_ready;
    end
  end

  task automatic drive_frame(input int base, input int n, input bit gap);
    int r;
    int c;
    int w;
    r = 0;
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pixel_in = pix(base + i);
      pixel_valid = 1'b1;
      #3;
      w = 0;
      while (!pixel_ready && w < 100) begin
        @(negedge clk);
        #3;
        w++;
      end
      if (!pixel_ready) begin
        chk++;
        err++;
        $display("FAIL pixel_ready_timeout got=0 exp=1");
        pixel_valid = 1'b0;
        return;
      end
      img[r][c] = pixel_in;
      if (r >= 2 && c >= 2)
        sb.push_back('{build(r, c), (r == H - 1 && c == W - 1), cyc + 1});
      @(posedge clk);
      if (c == W - 1) begin
        c = 0;
        r = (r == H - 1) ? 0 : r + 1;
      end else begin
        c++;
      end
      if (gap) begin
        #1;
        pixel_valid = 1'b0;
        @(negedge clk);
      end
    end
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic end_check(input string name, input int exp_n);
    repeat (6) @(negedge clk);
    #3;
    chk++;
    if (win_cnt !== exp_n || sb.size() != 0) begin
      err++;
      $display("FAIL %s_count got=%0d left=%0d exp=%0d",
               name, win_cnt, sb.size(), exp_n);
    end
    win_cnt = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pixel_valid = 1'b0;
    pixel_in = '0;
    window_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk++;
    if (pixelData !== '0 || window_valid !== 1'b0 || frame_done !== 1'b0 ||
        busy !== 1'b0 || pixel_ready !== 1'b1) begin
      err++;
      $display("FAIL reset_state got=%b%b%b%b exp=0001 data=%h",
               window_valid, frame_done, busy, pixel_ready, pixelData);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    win_cnt = 0;
    fork
      drive_frame(0, 16, 1'b0);
      begin
        int w;
        w = 0;
        do begin
          @(negedge clk);
          #2;
          w++;
        end while (!window_valid && w < 100);
        chk++;
        if (pixelData[215:192] !== 24'h004080 ||
            pixelData[23:0] !== 24'h0A4A8A) begin
          err++;
          $display("FAIL first_window got=%h..%h exp=004080..0a4a8a",
                   pixelData[215:192], pixelData[23:0]);
        end
      end
    join
    end_check("basic", 4);
  endtask

  task automatic test_backpressure;
    fork
      drive_frame(0, 16, 1'b0);
      begin
        int w;
        logic [215:0] held;
        w = 0;
        do begin
          @(negedge clk);
          #1;
          w++;
        end while (!window_valid && w < 100);
        window_ready = 1'b0;
        held = pixelData;
        repeat (5) begin
          @(negedge clk);
          #1;
          chk++;
          if (pixel_ready !== 1'b0 || window_valid !== 1'b1 ||
              pixelData !== held) begin
            err++;
            $display("FAIL stall got rdy=%b wv=%b exp rdy=0 wv=1",
                     pixel_ready, window_valid);
          end
        end
        window_ready = 1'b1;
        #1;
        chk++;
        if (pixel_ready !== 1'b1) begin
          err++;
          $display("FAIL release_ready got=%b exp=1", pixel_ready);
        end
      end
    join
    end_check("backpressure", 4);
  endtask

  task automatic test_gapped;
    drive_frame(0, 16, 1'b1);
    end_check("gapped", 4);
  endtask

  task automatic test_midframe_reset;
    drive_frame(150, 10, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk++;
    if (pixelData !== '0 || window_valid !== 1'b0 ||
        frame_done !== 1'b0 || busy !== 1'b0 || pixel_ready !== 1'b1) begin
      err++;
      $display("FAIL midreset_state got wv=%b fd=%b busy=%b rdy=%b",
               window_valid, frame_done, busy, pixel_ready);
    end
    sb.delete();
    win_cnt = 0;
    drive_frame(0, 16, 1'b0);
    end_check("midreset", 4);
  endtask

  task automatic test_back_to_back;
    fork
      begin
        drive_frame(0, 16, 1'b0);
        drive_frame(100, 16, 1'b0);
      end
      begin
        int w;
        w = 0;
        do begin
          @(negedge clk);
          #2;
          w++;
        end while (!frame_done && w < 200);
        chk++;
        if (!frame_done) begin
          err++;
          $display("FAIL b2b_frame_done got=0 exp=1");
        end else begin
          chk++;
          if (busy !== 1'b0 || pixel_valid !== 1'b1 ||
              pixel_in !== pix(100)) begin
            err++;
            $display("FAIL b2b_start got busy=%b pv=%b px=%h exp 0 1 %h",
                     busy, pixel_valid, pixel_in, pix(100));
          end
          @(negedge clk);
          #2;
          chk++;
          if (busy !== 1'b1) begin
            err++;
            $display("FAIL b2b_busy got=%b exp=1", busy);
          end
        end
      end
    join
    end_check("b2b", 8);
  endtask

  task automatic test_intensity;
    drive_frame(37, 16, 1'b0);
    end_check("intensity", 4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_midframe_reset();
    test_back_to_back();
    test_intensity();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_window_gen.md
Name: pixel_window_gen

Overview:
- Producer side of the 3x3 pixel-grid interface consumed by the intensity stage.
- Accepts a raster-order stream of 24-bit RGB pixels and keeps two line buffers.
- Emits one 216-bit 3x3 window per interior pixel position.
- Output data/valid connect directly to intensity pixelData/intensity_enable.

Parameters:
- IMG_WIDTH, 16, pixels per row (>=3).
- IMG_HEIGHT, 16, rows per frame (>=3).
- COL_BITS, 4, column counter width (>= clog2(IMG_WIDTH)).
- ROW_BITS, 4, row counter width (>= clog2(IMG_HEIGHT)).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- pixel_in  input  24  {R[23:16], G[15:8], B[7:0]}
- pixel_valid  input  1  pixel_in valid this cycle
- pixel_ready  output  1  block can accept pixel_in
- pixelData  output  216  3x3 window; pixel k at [215-24k -: 24], k=0 top-left, row-major, k=8 bottom-right; RGB order inside each pixel
- window_valid  output  1  pixelData valid; drives intensity_enable
- window_ready  input  1  downstream accepts window this cycle
- frame_done  output  1  one-cycle pulse after last pixel of frame accepted
- busy  output  1  high from first accepted pixel until frame_done

Behaviour:
- Reset (rst=1 at clk edge): pixelData=0, window_valid=0, frame_done=0, busy=0, pixel_ready=1. Counters cleared, state=IDLE. Line buffer contents do not matter.
- Mid-frame reset discards the partial frame; the next accepted pixel is (0,0).
- Accept condition: pixel_valid && pixel_ready.
- pixel_ready = !window_valid || window_ready, combinational. At most one pending window, no overflow.
- Window emit: window_valid clears when window_valid && window_ready.
- Output hold: pixelData is held stable while window_valid && !window_ready.
- Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1. col increments per accepted pixel. At col==IMG_WIDTH-1, col wraps to 0 and row increments.
- On accept of pixel p at (row,col), in order:
  - Window columns shift left: window col0 <= col1, col1 <= col2.
  - New col2 = {line2[col], line1[col], p}, top to bottom.
  - line2[col] <= line1[col]; line1[col] <= p.
- Window output condition: accept with row>=2 && col>=2.
  - Next edge: pixelData <= shifted window; window_valid <= 1.
  - Latency is 1 cycle from accepting edge to window_valid high.
  - Window is centred on (row-1, col-1). Edge pixels never produce windows.
  - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Row wrap: window columns hold stale data from the previous row. col>=2 guarantees two fresh shifts first, so no stale column reaches the output.
- States:
  - IDLE: busy=0; first accept -> FILL.
  - FILL: row<2; no windows; entering row 2 -> STREAM.
  - STREAM: emits windows; accept of (IMG_HEIGHT-1, IMG_WIDTH-1) -> DONE.
  - DONE: one cycle; frame_done=1, counters=0; -> IDLE.
- Last-pixel timing: the last pixel's window_valid and frame_done assert in the same cycle. busy drops that cycle.
- In DONE: a pending window stays valid until accepted. pixel_ready follows the normal rule, so a new frame may start in DONE and counts as (0,0).
- pixel_valid with !pixel_ready: pixel_in is ignored. The source must hold it; the block does not latch it.
- Arithmetic: counters compare with == against IMG_WIDTH-1 / IMG_HEIGHT-1, never relying on natural overflow. No pixel arithmetic; data passes bit-exact.

Test Plan:
- Basic window, W=H=4, window_ready=1:
  - Stimulus: stream 16 pixels, idx i -> {i, i+64, i+128}.
  - Response: exactly 4 windows.
  - First window, 1 cycle after idx 10 accepted: pixels idx {0,1,2,4,5,6,8,9,10}, pixelData[215:192]=0x0040_80, [23:0]=0x0A4A8A.
  - Last window: idx {5,6,7,9,10,11,13,14,15}.
  - frame_done pulses with window 4.
- Backpressure:
  - Stimulus: hold window_ready=0 for 5 cycles after first window_valid.
  - Response: pixel_ready=0 and pixelData stable throughout. Release -> window accepted, pixel_ready=1 same cycle, no pixel lost, remaining windows as in basic case.
- Gapped input:
  - Stimulus: pixel_valid toggled 1/0 every cycle.
  - Response: same 4 windows and contents as basic case; windows appear only 1 cycle after accepts of idx 10, 11, 14, 15.
- Reset mid-frame:
  - Stimulus: assert rst after idx 9 accepted, then send a full fresh frame.
  - Response: outputs 0 the cycle after reset. Fresh frame gives exactly 4 correct windows, none containing old data.
- Back-to-back frames:
  - Stimulus: second frame starts the cycle frame_done is high, values idx+100.
  - Response: 8 windows total. Second frame's first window = idx {100,101,102,104,105,106,108,109,110} in R; busy re-asserts.
- Intensity integration:
  - Stimulus: connect pixelData/window_valid to intensity pixelData/intensity_enable.
  - Response: each iGrid byte = R/4 + G/2 + B/4 of the matching window pixel, checked for all 4 windows.
